// File: rtl/bcd_tmr_ctrl.sv
// Four-digit BCD up/down timer controller with terminal-count detection,
// optional auto-reload and a sticky error flag for non-BCD presets.
module bcd_tmr_ctrl (
   input  logic        CLK,
   input  logic        CDN,
   input  logic        LD,
   input  logic [15:0] P,
   input  logic        DNUP,
   input  logic        START,
   input  logic        STOP,
   input  logic        ARL,
   input  logic        TICK,
   output logic [15:0] Q,
   output logic        RUN,
   output logic        DONE,
   output logic        TC,
   output logic        ERR
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_nextState;

   logic [15:0] r_q;
   logic [15:0] r_lim;
   logic        r_dir;
   logic        r_tc;
   logic        r_err;
   logic        r_reload;

   logic [15:0] w_s;
   logic [15:0] w_t;
   logic [15:0] w_step;
   logic        w_pValid;
   logic        w_ldAct;
   logic        w_startAct;
   logic        w_stopAct;
   logic        w_stepEn;
   logic        w_qAtT;
   logic        w_stepHitsT;

   function automatic logic [15:0] bcdInc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [15:0] bcdDec(input logic [15:0] v);
      logic [15:0] r;
      logic        borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (borrow) begin
            if (r[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic bcdValid(input logic [15:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (v[4*i +: 4] > 4'd9) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

   // Start/terminal values depend on the latched direction, not the live DNUP pin.
   always_comb begin
      w_s         = r_dir ? r_lim : 16'h0000;
      w_t         = r_dir ? 16'h0000 : r_lim;
      w_step      = r_dir ? bcdDec(r_q) : bcdInc(r_q);
      w_pValid    = bcdValid(P);
      w_qAtT      = (r_q == w_t);
      w_stepHitsT = (w_step == w_t);
      w_ldAct     = LD && (r_state != S_RUN);
      w_stopAct   = STOP && (r_state == S_RUN);
      w_startAct  = !w_ldAct && START &&
                    ((r_state == S_IDLE) || (r_state == S_PAUSE));
      w_stepEn    = (r_state == S_RUN) && TICK && !STOP;
   end

   always_ff @(posedge CLK or negedge CDN) begin
      if (!CDN) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE, S_PAUSE: begin
            if (w_ldAct) begin
               if (w_pValid) begin
                  w_nextState = S_IDLE;
               end
            end else if (w_startAct) begin
               w_nextState = w_qAtT ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (w_stopAct) begin
               w_nextState = S_PAUSE;
            end else if (w_stepEn && !r_reload && w_stepHitsT && !ARL) begin
               w_nextState = S_DONE;
            end
         end
         S_DONE: begin
            if (w_ldAct && w_pValid) begin
               w_nextState = S_IDLE;
            end
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   // A pending reload replaces the next step with a jump back to the start value.
   always_ff @(posedge CLK or negedge CDN) begin
      if (!CDN) begin
         r_q      <= 16'h0000;
         r_lim    <= 16'h0000;
         r_dir    <= 1'b0;
         r_tc     <= 1'b0;
         r_err    <= 1'b0;
         r_reload <= 1'b0;
      end else begin
         r_tc <= 1'b0;
         if (w_ldAct) begin
            if (w_pValid) begin
               r_lim    <= P;
               r_dir    <= DNUP;
               r_q      <= DNUP ? P : 16'h0000;
               r_err    <= 1'b0;
               r_reload <= 1'b0;
            end else begin
               r_err <= 1'b1;
            end
         end else if (w_startAct) begin
            r_reload <= 1'b0;
            if (w_qAtT) begin
               r_tc <= 1'b1;
            end
         end else if (w_stopAct) begin
            r_reload <= 1'b0;
         end else if (w_stepEn) begin
            if (r_reload) begin
               r_q      <= w_s;
               r_reload <= 1'b0;
            end else begin
               r_q <= w_step;
               if (w_stepHitsT) begin
                  r_tc     <= 1'b1;
                  r_reload <= ARL;
               end
            end
         end
      end
   end

   always_comb begin
      Q    = r_q;
      RUN  = (r_state == S_RUN);
      DONE = (r_state == S_DONE);
      TC   = r_tc;
      ERR  = r_err;
   end

endmodule
